// File: rtl/lfu_victim_sel.sv
// LFU victim selector: per-way usage counters with halving on saturation,
// plus a serial min-scan over a snapshot that answers victim requests.

module lfu_victim_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hit_i,
  input  logic             fill_i,
  input  logic             age_i,
  output logic [CNT_W-1:0] cnt_o
);
  localparam logic [CNT_W-1:0] AGE_V = CNT_W'(1) << (CNT_W - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fill beats everything; a saturating hit resets its own way to half+1.
  always_comb begin
    cnt_d = cnt_q;
    if (fill_i)      cnt_d = '0;
    else if (age_i)  cnt_d = hit_i ? AGE_V : (cnt_q >> 1);
    else if (hit_i)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module lfu_victim_sel #(
  parameter int WAYS  = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hit_vld_i,
  input  logic [IDX_W-1:0] hit_way_i,
  input  logic             fill_vld_i,
  input  logic [IDX_W-1:0] fill_way_i,
  input  logic [WAYS-1:0]  way_valid_i,
  input  logic             vict_req_i,
  output logic             busy_o,
  output logic             vict_ack_o,
  output logic [IDX_W-1:0] vict_way_o,
  output logic [CNT_W-1:0] vict_cnt_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WAYS - 1);

  logic [WAYS-1:0][CNT_W-1:0] cnt;
  logic                       hit_ok, fill_ok, age;
  logic [CNT_W-1:0]           hit_cnt;

  assign hit_ok  = hit_vld_i  && (int'(hit_way_i)  < WAYS);
  assign fill_ok = fill_vld_i && (int'(fill_way_i) < WAYS);
  assign hit_cnt = hit_ok ? cnt[hit_way_i] : '0;
  assign age     = hit_ok && (hit_cnt == MAX);

  for (genvar g = 0; g < WAYS; g++) begin : g_lane
    lfu_victim_lane #(.CNT_W(CNT_W)) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .hit_i  (hit_ok  && (hit_way_i  == IDX_W'(g))),
      .fill_i (fill_ok && (fill_way_i == IDX_W'(g))),
      .age_i  (age),
      .cnt_o  (cnt[g])
    );
  end

  logic [1:0]                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CNT_W:0]             best_key_q, best_key_d;
  logic [IDX_W-1:0]           best_way_q, best_way_d;
  logic [WAYS-1:0][CNT_W-1:0] snap_cnt_q, snap_cnt_d;
  logic [WAYS-1:0]            snap_vld_q, snap_vld_d;
  logic                       busy_q, busy_d, ack_q, ack_d;
  logic [IDX_W-1:0]           vway_q, vway_d;
  logic [CNT_W-1:0]           vcnt_q, vcnt_d;

  // Key puts validity in the MSB so invalid ways always sort first.
  logic [CNT_W:0]   cur_key, nxt_key;
  logic [IDX_W-1:0] nxt_way;
  logic             better;

  assign cur_key = {snap_vld_q[idx_q], snap_cnt_q[idx_q]};
  assign better  = cur_key < best_key_q;
  assign nxt_key = better ? cur_key : best_key_q;
  assign nxt_way = better ? idx_q : best_way_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_key_d = best_key_q;
    best_way_d = best_way_q;
    snap_cnt_d = snap_cnt_q;
    snap_vld_d = snap_vld_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    vway_d     = vway_q;
    vcnt_d     = vcnt_q;
    case (state_q)
      S_IDLE: if (vict_req_i) begin
        state_d    = S_SCAN;
        busy_d     = 1'b1;
        snap_cnt_d = cnt;
        snap_vld_d = way_valid_i;
        idx_d      = '0;
        best_key_d = '1;
        best_way_d = '0;
      end
      S_SCAN: begin
        best_key_d = nxt_key;
        best_way_d = nxt_way;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          vway_d  = nxt_way;
          vcnt_d  = nxt_key[CNT_W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      best_key_q <= '1;
      best_way_q <= '0;
      snap_cnt_q <= '0;
      snap_vld_q <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      vway_q     <= '0;
      vcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_key_q <= best_key_d;
      best_way_q <= best_way_d;
      snap_cnt_q <= snap_cnt_d;
      snap_vld_q <= snap_vld_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      vway_q     <= vway_d;
      vcnt_q     <= vcnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign vict_ack_o = ack_q;
  assign vict_way_o = vway_q;
  assign vict_cnt_o = vcnt_q;
endmodule

// File: tb/tb_lfu_victim_sel.sv
// Directed bench for lfu_victim_sel: a per-cycle reference model plus
// literal expectations on counter values read back through scans.

module tb_lfu_victim_sel;
  localparam int WAYS  = 4;
  localparam int CNT_W = 4;
  localparam int IDX_W = 2;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hit_vld = 1'b0, fill_vld = 1'b0, vict_req = 1'b0;
  logic [IDX_W-1:0] hit_way = '0, fill_way = '0;
  logic [WAYS-1:0]  way_valid = '1;
  logic             busy, vict_ack;
  logic [IDX_W-1:0] vict_way;
  logic [CNT_W-1:0] vict_cnt;

  int n_chk = 0;
  int n_bad = 0;

  lfu_victim_sel #(.WAYS(WAYS), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .hit_vld_i(hit_vld), .hit_way_i(hit_way),
    .fill_vld_i(fill_vld), .fill_way_i(fill_way),
    .way_valid_i(way_valid), .vict_req_i(vict_req),
    .busy_o(busy), .vict_ack_o(vict_ack),
    .vict_way_o(vict_way), .vict_cnt_o(vict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counters as plain integers, victim chosen at accept time.
  int mcnt[WAYS];
  int phase = 0, left = 0, pway = 0, pcnt = 0;
  int e_busy = 0, e_ack = 0, e_way = 0, e_cnt = 0;
  bit started = 0;

  always @(posedge clk) begin
    int b, h, f;
    started = 1;
    if (rst) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      phase = 0; e_way = 0; e_cnt = 0;
    end else begin
      if (phase == 0 && vict_req) begin
        b = 0;
        for (int i = 1; i < WAYS; i++)
          if ((!way_valid[i] && way_valid[b]) ||
              (way_valid[i] == way_valid[b] && mcnt[i] < mcnt[b])) b = i;
        pway = b; pcnt = mcnt[b]; phase = 1; left = WAYS;
      end else if (phase == 1) begin
        left--;
        if (left == 0) begin phase = 2; e_way = pway; e_cnt = pcnt; end
      end else if (phase == 2) phase = 0;
      h = int'(hit_way); f = int'(fill_way);
      if (hit_vld && h < WAYS) begin
        if (mcnt[h] == MAX) begin
          foreach (mcnt[i]) mcnt[i] = mcnt[i] / 2;
          mcnt[h] = MAX / 2 + 1;
        end else mcnt[h]++;
      end
      if (fill_vld && f < WAYS) mcnt[f] = 0;
    end
    e_busy = (phase == 1);
    e_ack  = (phase == 2);
  end

  always @(negedge clk) if (started) begin
    chk("m_busy", busy, e_busy);
    chk("m_ack", vict_ack, e_ack);
    chk("m_way", vict_way, e_way);
    chk("m_cnt", vict_cnt, e_cnt);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic hit(input int w, input int n);
    for (int k = 0; k < n; k++) begin
      hit_vld = 1'b1; hit_way = IDX_W'(w); tick();
    end
    hit_vld = 1'b0;
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
    for (int w = 0; w < WAYS; w++) begin
      fill_vld = 1'b1; fill_way = IDX_W'(w); tick();
    end
    fill_vld = 1'b0;
    hit(0, c0); hit(1, c1); hit(2, c2); hit(3, c3);
  endtask

  // Issues one request from IDLE; lat counts cycles from accept to ack.
  task automatic scan(input logic [WAYS-1:0] vm, output int way, output int cnt,
                      output int lat, output int nbusy);
    way_valid = vm; vict_req = 1'b1;
    @(posedge clk);
    tick(); vict_req = 1'b0;
    lat = 1; nbusy = 0; way = -1; cnt = -1;
    while (!vict_ack && lat < 20) begin
      if (busy) nbusy++;
      tick(); lat++;
    end
    if (vict_ack) begin way = int'(vict_way); cnt = int'(vict_cnt); end
    else chk("ack_timeout", 0, 1);
    tick();
    way_valid = '1;
  endtask

  task automatic probe(input string nm, input int w, input int exp);
    int wy, c, l, nb;
    scan(~(WAYS'(1) << w), wy, c, l, nb);
    chk({nm, "_way"}, wy, w);
    chk({nm, "_cnt"}, c, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wy, c, l, nb, acks, gap;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ack", vict_ack, 0);
    chk("rst_way", vict_way, 0);
    chk("rst_cnt", vict_cnt, 0);

    scan('1, wy, c, l, nb);
    chk("t1_way", wy, 0); chk("t1_cnt", c, 0);
    chk("t1_lat", l, WAYS + 1); chk("t1_busy_cycles", nb, WAYS);

    set_counts(3, 1, 2, 5);
    scan('1, wy, c, l, nb);
    chk("t2_way", wy, 1); chk("t2_cnt", c, 1);

    set_counts(3, 1, 9, 5);
    scan(4'b1011, wy, c, l, nb);
    chk("t3_inv_way", wy, 2); chk("t3_inv_cnt", c, 9);
    set_counts(2, 2, 7, 2);
    scan('1, wy, c, l, nb);
    chk("t3_tie_way", wy, 0); chk("t3_tie_cnt", c, 2);
    scan('0, wy, c, l, nb);
    chk("t3_allinv_way", wy, 0); chk("t3_allinv_cnt", c, 2);

    set_counts(15, 6, 3, 0);
    hit(0, 1);
    probe("age0", 0, 8); probe("age1", 1, 3);
    probe("age2", 2, 1); probe("age3", 3, 0);
    hit_vld = 1'b1; hit_way = 2'd2; fill_vld = 1'b1; fill_way = 2'd2; tick();
    hit_vld = 1'b0; fill_vld = 1'b0;
    probe("hf_same", 2, 0);
    hit(0, 7);
    hit_vld = 1'b1; hit_way = 2'd0; fill_vld = 1'b1; fill_way = 2'd1; tick();
    hit_vld = 1'b0; fill_vld = 1'b0;
    probe("hf_diff_fill", 1, 0); probe("hf_diff_hit", 0, 8);
    hit(0, 7); hit(1, 4);
    hit_vld = 1'b1; hit_way = 2'd0; fill_vld = 1'b1; fill_way = 2'd0; tick();
    hit_vld = 1'b0; fill_vld = 1'b0;
    probe("hf_age_fill", 0, 0); probe("hf_age_other", 1, 2);

    set_counts(4, 1, 4, 4);
    vict_req = 1'b1;
    @(posedge clk);
    tick(); vict_req = 1'b0;
    wy = -1; c = -1;
    hit_vld = 1'b1; hit_way = 2'd1;
    for (int k = 1; k <= 5; k++) begin
      if (vict_ack) begin wy = int'(vict_way); c = int'(vict_cnt); end
      tick();
    end
    hit_vld = 1'b0;
    chk("t5_snap_way", wy, 1); chk("t5_snap_cnt", c, 1);
    probe("t5_live", 1, 6);

    vict_req = 1'b1;
    @(posedge clk);
    tick(); vict_req = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t6_busy", busy, 0); chk("t6_ack", vict_ack, 0);
    chk("t6_way", vict_way, 0); chk("t6_cnt", vict_cnt, 0);
    acks = 0;
    repeat (6) begin if (vict_ack) acks++; tick(); end
    chk("t6_no_ack", acks, 0);
    probe("t6_cnt_cleared", 2, 0);

    set_counts(1, 0, 2, 3);
    vict_req = 1'b1;
    gap = 0; acks = 0;
    for (int k = 0; k < 40 && acks < 2; k++) begin
      tick();
      if (acks == 1) gap++;
      if (vict_ack) acks++;
    end
    vict_req = 1'b0;
    chk("t7_two_acks", acks, 2);
    chk("t7_gap", gap, WAYS + 2);
    chk("t7_way", vict_way, 1);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
